// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift/compare ops plus iterative multu/divu.
// Latency: done 1 cycle after acceptance (single-cycle ops), WIDTH+1 cycles for multu/divu.
// Backpressure: busy high from acceptance through done; start is ignored while busy.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_q;
    logic             op_div;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic             accept;
    logic             multi;
    logic             last_iter;
    logic [WIDTH-1:0] single_res;

    logic [WIDTH:0]   m_sum;
    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;
    logic [WIDTH:0]   d_sh;
    logic             d_ok;
    logic [WIDTH-1:0] d_rem;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign accept    = start && (state == IDLE);
    assign multi     = (ALUOp[3:1] == 3'b100);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = multi ? CALC : DONE;
            CALC:    if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Oversized shift amounts fall out of the language semantics: srl -> 0, sra -> sign fill.
    always_comb begin
        single_res = '0;
        case (ALUOp)
            4'b0000: single_res = A + B;
            4'b0001: single_res = A - B;
            4'b0010: single_res = A & B;
            4'b0011: single_res = A | B;
            4'b0100: single_res = A >> B;
            4'b0101: single_res = $signed(A) >>> B;
            4'b0110: single_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b0111: single_res = {{(WIDTH-1){1'b0}}, A < B};
            default: single_res = '0;
        endcase
    end

    // Multiply: {work_hi,work_lo} is the partial product, multiplier bits shift out of work_lo.
    // Divide: work_hi is the partial remainder, quotient bits shift into work_lo.
    always_comb begin
        m_sum   = {1'b0, work_hi} + {1'b0, (work_lo[0] ? b_q : {WIDTH{1'b0}})};
        m_hi    = m_sum[WIDTH:1];
        m_lo    = {m_sum[0], work_lo[WIDTH-1:1]};
        d_sh    = {work_hi, work_lo[WIDTH-1]};
        d_ok    = (d_sh >= {1'b0, b_q});
        d_rem   = d_ok ? WIDTH'(d_sh - {1'b0, b_q}) : d_sh[WIDTH-1:0];
        d_q     = {work_lo[WIDTH-2:0], d_ok};
        step_hi = op_div ? d_rem : m_hi;
        step_lo = op_div ? d_q   : m_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            C       <= '0;
            HI      <= '0;
            b_q     <= '0;
            op_div  <= 1'b0;
            work_hi <= '0;
            work_lo <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        b_q     <= B;
                        op_div  <= ALUOp[0];
                        work_hi <= '0;
                        work_lo <= A;
                        if (!multi) begin
                            C  <= single_res;
                            HI <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt     <= cnt + 1'b1;
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    if (last_iter) begin
                        C  <= step_lo;
                        HI <= step_hi;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Randomized and directed checks of seq_alu (WIDTH=32) against a plain-arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic [31:0] C;
    logic [31:0] HI;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .ALUOp(ALUOp),
        .C(C), .HI(HI), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: what each op means arithmetically, and how many cycles until done.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] c, output logic [31:0] hi, output int lat);
        logic [63:0] p;
        c = 32'd0; hi = 32'd0; lat = 1;
        case (op)
            4'd0: c = a + b;
            4'd1: c = a - b;
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            4'd5: c = (b >= 32) ? {32{a[31]}} : ($signed(a) >>> b[4:0]);
            4'd6: c = {31'd0, ($signed(a) < $signed(b))};
            4'd7: c = {31'd0, (a < b)};
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                c = p[31:0]; hi = p[63:32]; lat = 33;
            end
            4'd9: begin
                if (b == 0) begin c = 32'hFFFF_FFFF; hi = a; end
                else begin c = a / b; hi = a % b; end
                lat = 33;
            end
            default: ;
        endcase
    endfunction

    // Issues one op from IDLE, scrambles the inputs after acceptance, and waits (bounded) for done.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] c, output logic [31:0] hi,
                          output int busy_bad);
        @(negedge clk);
        start = 1'b1; ALUOp = op; A = a; B = b;
        @(posedge clk);
        #1;
        start = 1'b0; A = $urandom; B = $urandom; ALUOp = 4'($urandom);
        lat = -1; busy_bad = 0; c = 32'hx; hi = 32'hx;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = n; c = C; hi = HI;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; ALUOp = 4'd0; A = 32'h1234; B = 32'h1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({C, HI, busy, done} !== 66'd0) $display("FAIL reset_state: C=%h HI=%h busy=%b done=%b, required all 0", C, HI, busy, done);
        else n_pass++;
        start = 1'b0; reset = 1'b0;
    endtask

    task automatic test_sra();
        int lat, bb; logic [31:0] c, hi;
        run_op(4'b0101, 32'h8000_0000, 32'd4, lat, c, hi, bb);
        n_checks++;
        if (lat !== 1 || c !== 32'hF800_0000 || hi !== 32'd0)
            $display("FAIL sra_b4: lat=%0d C=%h HI=%h, required lat=1 C=f8000000 HI=0", lat, c, hi);
        else n_pass++;
        run_op(4'b0101, 32'h8000_0000, 32'd40, lat, c, hi, bb);
        n_checks++;
        if (lat !== 1 || c !== 32'hFFFF_FFFF) $display("FAIL sra_b40: lat=%0d C=%h, required lat=1 C=ffffffff", lat, c);
        else n_pass++;
        run_op(4'b0100, 32'h8000_0000, 32'd32, lat, c, hi, bb);
        n_checks++;
        if (c !== 32'd0) $display("FAIL srl_b32: C=%h, required 0", c);
        else n_pass++;
    endtask

    task automatic test_multu();
        int lat, bb; logic [31:0] c, hi;
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd2, lat, c, hi, bb);
        n_checks++;
        if (lat !== 33 || hi !== 32'd1 || c !== 32'hFFFF_FFFE)
            $display("FAIL multu_max: lat=%0d HI=%h C=%h, required lat=33 HI=1 C=fffffffe", lat, hi, c);
        else n_pass++;
        n_checks++;
        if (bb !== 0) $display("FAIL multu_busy: busy low in %0d of cycles 1..33, required 0", bb);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL multu_idle: busy=%b done=%b after done, required 0 0", busy, done);
        else n_pass++;
        n_checks++;
        if (C !== 32'hFFFF_FFFE || HI !== 32'd1) $display("FAIL multu_hold: C=%h HI=%h, required fffffffe 00000001", C, HI);
        else n_pass++;
    endtask

    task automatic test_divu();
        int lat, bb; logic [31:0] c, hi;
        run_op(4'b1001, 32'd100, 32'd7, lat, c, hi, bb);
        n_checks++;
        if (lat !== 33 || c !== 32'd14 || hi !== 32'd2)
            $display("FAIL divu_100_7: lat=%0d C=%0d HI=%0d, required lat=33 C=14 HI=2", lat, c, hi);
        else n_pass++;
        run_op(4'b1001, 32'd5, 32'd0, lat, c, hi, bb);
        n_checks++;
        if (lat !== 33 || c !== 32'hFFFF_FFFF || hi !== 32'd5)
            $display("FAIL divu_by0: lat=%0d C=%h HI=%h, required lat=33 C=ffffffff HI=5", lat, c, hi);
        else n_pass++;
    endtask

    task automatic test_ignore_start();
        int lat; logic [31:0] ec, ehi;
        lat = -1;
        @(negedge clk);
        start = 1'b1; ALUOp = 4'b1000; A = 32'h0001_0003; B = 32'h0002_0005;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 10) begin
                start = 1'b1; ALUOp = 4'b0000; A = 32'd1000; B = 32'd234;
            end
            if (done === 1'b1) begin lat = n; break; end
        end
        model(4'b1000, 32'h0001_0003, 32'h0002_0005, ec, ehi, lat);
        n_checks++;
        if (C !== ec || HI !== ehi) $display("FAIL ignore_multu: C=%h HI=%h, required %h %h", C, HI, ec, ehi);
        else n_pass++;
        // start stays high: the add is accepted on the edge after the IDLE cycle following done.
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL ignore_idle: busy=%b after done, required 0", busy);
        else n_pass++;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || C !== 32'd1234 || HI !== 32'd0)
            $display("FAIL ignore_add: done=%b C=%0d HI=%0d, required done=1 C=1234 HI=0", done, C, HI);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; ALUOp = 4'b1001; A = 32'd999; B = 32'd10;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n < 15; n++) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (C !== 32'd0 || HI !== 32'd0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid: C=%h HI=%h busy=%b done=%b, required 0 0 0 0", C, HI, busy, done);
        else n_pass++;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL reset_no_done: %0d done pulses after abort, required 0", seen);
        else n_pass++;
        // Reset coincident with start must win.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; ALUOp = 4'b0011; A = 32'hF0; B = 32'h0F;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || C !== 32'd0) $display("FAIL reset_vs_start: busy=%b C=%h, required 0 0", busy, C);
        else n_pass++;
    endtask

    task automatic test_slt();
        int lat, bb; logic [31:0] c, hi;
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, lat, c, hi, bb);
        n_checks++;
        if (c !== 32'd0) $display("FAIL sltu: C=%h, required 0", c);
        else n_pass++;
        run_op(4'b0110, 32'hFFFF_FFFF, 32'd1, lat, c, hi, bb);
        n_checks++;
        if (c !== 32'd1) $display("FAIL slt: C=%h, required 1", c);
        else n_pass++;
        run_op(4'b1111, 32'hFFFF_FFFF, 32'd1, lat, c, hi, bb);
        n_checks++;
        if (lat !== 1 || c !== 32'd0 || hi !== 32'd0) $display("FAIL undef_op: lat=%0d C=%h HI=%h, required 1 0 0", lat, c, hi);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat, elat, bb; logic [31:0] c, hi, ec, ehi, a, b; logic [3:0] op;
        for (int i = 0; i < 60; i++) begin
            op = (i % 4 == 3) ? 4'($urandom) : 4'($urandom_range(0, 9));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom_range(0, 40);
                1: b = 32'd0;
                default: b = $urandom;
            endcase
            run_op(op, a, b, lat, c, hi, bb);
            model(op, a, b, ec, ehi, elat);
            n_checks++;
            if (lat !== elat || c !== ec || hi !== ehi || bb !== 0)
                $display("FAIL rand_%0d op=%h a=%h b=%h: lat=%0d C=%h HI=%h busy_low=%0d, required lat=%0d C=%h HI=%h busy_low=0",
                         i, op, a, b, lat, c, hi, bb, elat, ec, ehi);
            else n_pass++;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUOp = '0;
        test_reset();
        test_sra();
        test_multu();
        test_divu();
        test_ignore_start();
        test_reset_mid();
        test_slt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal: 8..64, power of two).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request strobe; operands and op are sampled when start=1 and busy=0.
REQ-005 SHALL have port A  input  WIDTH  first operand.
REQ-006 SHALL have port B  input  WIDTH  second operand / shift amount / divisor.
REQ-007 SHALL have port ALUOp  input  4  operation select.
REQ-008 SHALL have port C  output  WIDTH  primary result (LO product / quotient for mult/div).
REQ-009 SHALL have port HI  output  WIDTH  secondary result (upper product / remainder); 0 for other ops.
REQ-010 SHALL have port busy  output  1  high while an accepted operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse when C/HI become valid.

Function
REQ-012 SHALL decode ALUOp: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 srl, 0101 sra, 0110 slt (signed), 0111 sltu, 1000 multu, 1001 divu; all other codes produce C=0, HI=0.
REQ-013 SHALL compute add/sub modulo 2^WIDTH, with no carry or overflow output.
REQ-014 SHALL use the full B value as shift amount; B>=WIDTH gives 0 for srl and all-copies-of-A[WIDTH-1] for sra.
REQ-015 SHALL return C={WIDTH-1 zeros, result bit} for slt/sltu.
REQ-016 SHALL implement FSM states IDLE, CALC and DONE.
REQ-017 SHALL transition IDLE->DONE on accepted start with single-cycle ops (incl. undefined codes), registering C/HI, so done=1 exactly 1 cycle after the accepting edge.
REQ-018 SHALL transition IDLE->CALC on accepted start with multu/divu, run exactly WIDTH iterations (one bit per cycle: shift-add multiply, restoring divide), then go to DONE; done=1 exactly WIDTH+1 cycles after the accepting edge.
REQ-019 SHALL transition DONE->IDLE unconditionally after one cycle; done is high only in DONE.
REQ-020 SHALL drive busy=1 in CALC and DONE and busy=0 in IDLE; a new start is accepted in the cycle after done.
REQ-021 SHALL ignore start while busy=1, leaving in-flight operands, iteration count and results unaffected.
REQ-022 SHALL produce the multu result {HI,C} as the full 2*WIDTH-bit unsigned product.
REQ-023 SHALL, for divu with B=0, produce C=all ones and HI=A after the full WIDTH+1 latency, with no exception output.
REQ-024 SHALL hold C/HI stable from done until the next accepted operation writes them; intermediate iteration values are never visible on C/HI.
REQ-025 SHALL latch A, B and ALUOp internally at acceptance; input changes during CALC have no effect.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, set state=IDLE, C=0, HI=0, busy=0, done=0 and clear the iteration counter, regardless of other inputs.
REQ-027 SHALL, when reset is asserted mid-CALC, abort the operation with no done pulse, and give reset priority over a coincident start.

Verification
REQ-028 SHALL verify, with WIDTH=32: start with ALUOp=0101, A=0x80000000, B=4 -> done 1 cycle later, C=0xF8000000, HI=0; with B=40 -> C=0xFFFFFFFF.
REQ-029 SHALL verify: multu with A=0xFFFFFFFF, B=2 -> done at cycle 33, HI=0x00000001, C=0xFFFFFFFE; busy high for cycles 1..33.
REQ-030 SHALL verify: divu with A=100, B=7 -> C=14, HI=2; divu with A=5, B=0 -> C=0xFFFFFFFF, HI=5.
REQ-031 SHALL verify: start pulsed with an add at cycle 10 of a multu -> ignored, multu result correct, then the add is accepted after done and gives its result 1 cycle later.
REQ-032 SHALL verify: reset at cycle 15 of divu -> next cycle C=0, HI=0, busy=0, and no done pulse follows.
REQ-033 SHALL verify: slt with A=0xFFFFFFFF, B=1 -> C=1; sltu with the same operands -> C=0; ALUOp=1111 -> C=0 with done after 1 cycle.
